// File: rtl/hex_display_pkg.sv
// Shared constants and the active-low hex-to-7-segment decoder used by the display path.
package hex_display_pkg;

    localparam int unsigned DIGIT_W   = 4;
    localparam logic [7:0]  SEG_BLANK = 8'hFF;

    // Active-low segment pattern {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'h0:    pattern = 7'h40;
            4'h1:    pattern = 7'h79;
            4'h2:    pattern = 7'h24;
            4'h3:    pattern = 7'h30;
            4'h4:    pattern = 7'h19;
            4'h5:    pattern = 7'h12;
            4'h6:    pattern = 7'h02;
            4'h7:    pattern = 7'h78;
            4'h8:    pattern = 7'h00;
            4'h9:    pattern = 7'h10;
            4'hA:    pattern = 7'h08;
            4'hB:    pattern = 7'h03;
            4'hC:    pattern = 7'h46;
            4'hD:    pattern = 7'h21;
            4'hE:    pattern = 7'h06;
            default: pattern = 7'h0E;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/display_scan_mux.sv
// Time-multiplexed digit scanner: scan counter, digit index and registered anode/segment drive.
// Optional leading-zero blanking selected by defining LEADING_ZERO_BLANK_EN.
module display_scan_mux
    import hex_display_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 50_000
) (
    input  logic                        clk_in,
    input  logic                        reset,
    input  logic [DIGIT_W*DIGITS-1:0]   count,
    input  logic [DIGITS-1:0]           dp_in,
    output logic [7:0]                  seg,
    output logic [DIGITS-1:0]           an
);

    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [SCAN_W-1:0]         scan_cnt;
    logic [IDX_W-1:0]          idx;
    logic                      scan_step;
    logic [DIGIT_W-1:0]        digit_val;
    logic [DIGIT_W*DIGITS-1:0] upper_digits;
    logic                      blank;
    logic [7:0]                seg_next;
    logic [DIGITS-1:0]         an_next;

    assign scan_step = (scan_cnt == SCAN_W'(SCAN_DIV - 1));

    always_comb begin
        digit_val    = count[DIGIT_W*idx +: DIGIT_W];
        upper_digits = count >> (DIGIT_W * idx);
        blank        = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        // Blank when this digit and every digit above it are zero; digit 0 always shows
        blank        = (idx != '0) && (upper_digits == '0);
`endif
        seg_next     = {~dp_in[idx], blank ? 7'h7F : hex_to_seg(digit_val)};
        an_next      = ~(DIGITS'(1) << idx);
    end

    // The digit currently indexed is latched onto the pins as the index moves on
    always_ff @(posedge clk_in) begin
        if (reset) begin
            scan_cnt <= '0;
            idx      <= '0;
            seg      <= SEG_BLANK;
            an       <= '1;
        end else if (scan_step) begin
            scan_cnt <= '0;
            seg      <= seg_next;
            an       <= an_next;
            idx      <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/multi_digit_hex_counter.sv
// N-digit hex up/down counter with tick prescaler, wrap carry pulse and multiplexed 7-seg drive.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits on the display.
module multi_digit_hex_counter
    import hex_display_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned TICK_DIV = 25_000_000,
    parameter int unsigned SCAN_DIV = 50_000
) (
    input  logic                        clk_in,
    input  logic                        reset,
    input  logic                        load,
    input  logic                        count_en,
    input  logic                        up,
    input  logic [DIGIT_W*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]           dp_in,
    output logic [DIGIT_W*DIGITS-1:0]   count,
    output logic                        carry_out,
    output logic [7:0]                  seg,
    output logic [DIGITS-1:0]           an
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PRE_W-1:0] prescaler;
    logic             tick;
    logic             wrap;

    assign tick = count_en && (prescaler == PRE_W'(TICK_DIV - 1));
    assign wrap = up ? (count == '1) : (count == '0);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            count     <= '0;
            prescaler <= '0;
            carry_out <= 1'b0;
        end else if (load) begin
            count     <= data_in;
            prescaler <= '0;
            carry_out <= 1'b0;
        end else begin
            carry_out <= tick && wrap;
            if (count_en)
                prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick)
                count <= up ? count + 1'b1 : count - 1'b1;
        end
    end

    display_scan_mux #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk_in (clk_in),
        .reset  (reset),
        .count  (count),
        .dp_in  (dp_in),
        .seg    (seg),
        .an     (an)
    );

endmodule
